// File: rtl/pe_operand_fetch.sv
// Operand fetch stage: issues lock-step reads to LANES SRAM banks, buffers the
// returned beats in a small FIFO and hands them to the PE array. Optional macro:
// PE_FETCH_ZERO_PAD_EN (all-ones lane address = padding lane, read suppressed, data 0).
module pe_operand_fetch #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 13,
  parameter int LANES      = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int PW        = $clog2(FIFO_DEPTH),
  localparam int LW        = PW + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [LANES-1:0]          valid,
  input  logic [LANES*ADDR_W-1:0]   addr_bus,
  output logic                      fetch_ready,
  output logic [LANES-1:0]          bank_rd_en,
  output logic [LANES*ADDR_W-1:0]   bank_addr,
  input  logic [LANES*DATA_W-1:0]   bank_rd_data,
  output logic [LANES*DATA_W-1:0]   pe_data,
  output logic [LANES-1:0]          pe_valid,
  input  logic                      pe_ready,
  output logic [LW-1:0]             fifo_level
);

  // Handshakes: a controller beat transfers on a cycle with en && valid != 0 &&
  // fetch_ready; a PE beat transfers on an edge with pe_valid != 0 && pe_ready.
  // Neither side may make its valid depend on the other side's ready.

  logic [LANES-1:0]        pad_mask;
  logic                    fire;
  logic [LW-1:0]           inflight;
  logic                    push;
  logic                    pop;
  logic                    empty;
  logic                    full;
  logic [LANES*DATA_W-1:0] wr_word;

  logic                    pipe_push  [RD_LAT];
  logic [LANES-1:0]        pipe_vmask [RD_LAT];
  logic [LANES-1:0]        pipe_rmask [RD_LAT];

  logic [LANES*DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [LANES-1:0]        mem_mask [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;

  always_comb begin
    pad_mask = '0;
`ifdef PE_FETCH_ZERO_PAD_EN
    for (int i = 0; i < LANES; i++)
      pad_mask[i] = (addr_bus[i*ADDR_W +: ADDR_W] == {ADDR_W{1'b1}});
`endif
  end

  // Credits: beats still in the read pipeline already own a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + LW'(pipe_push[i]);
  end

  assign fetch_ready = !reset &&
    (({1'b0, inflight} + {1'b0, fifo_level}) < (LW+1)'(FIFO_DEPTH));
  assign fire        = en && (valid != '0) && fetch_ready;
  assign bank_rd_en  = fire ? (valid & ~pad_mask) : '0;
  assign bank_addr   = addr_bus;

  assign push  = pipe_push[RD_LAT-1];
  assign empty = (fifo_level == '0);
  assign full  = (fifo_level == LW'(FIFO_DEPTH));
  assign pe_valid = empty ? '0 : mem_mask[rd_ptr];
  assign pe_data  = empty ? '0 : mem_data[rd_ptr];
  assign pop   = (pe_valid != '0) && pe_ready;

  // Lanes that were not actually read (masked off or padding) store zero.
  always_comb begin
    wr_word = '0;
    for (int i = 0; i < LANES; i++)
      if (pipe_rmask[RD_LAT-1][i])
        wr_word[i*DATA_W +: DATA_W] = bank_rd_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_push[i]  <= 1'b0;
        pipe_vmask[i] <= '0;
        pipe_rmask[i] <= '0;
      end
    end else begin
      pipe_push[0]  <= fire;
      pipe_vmask[0] <= fire ? valid : '0;
      pipe_rmask[0] <= bank_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_push[i]  <= pipe_push[i-1];
        pipe_vmask[i] <= pipe_vmask[i-1];
        pipe_rmask[i] <= pipe_rmask[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_mask[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= wr_word;
        mem_mask[wr_ptr] <= pipe_vmask[RD_LAT-1];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        fifo_level <= fifo_level + 1'b1;
      else if (pop && !push)
        fifo_level <= fifo_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full));
      assert (!(pop && empty));
    end
  end

endmodule

// File: tb/tb_pe_operand_fetch.sv
// Bench for pe_operand_fetch: directed stimulus, a bank SRAM responder and a
// queue-based model of issue order, read latency, credits and FIFO occupancy.
module tb_pe_operand_fetch;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 13;
  localparam int LANES      = 16;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  localparam int DW_ALL     = LANES * DATA_W;
  localparam int BW         = DW_ALL + LANES;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    en = 1'b0;
  logic [LANES-1:0]        valid = '0;
  logic [LANES*ADDR_W-1:0] addr_bus = '0;
  logic                    fetch_ready;
  logic [LANES-1:0]        bank_rd_en;
  logic [LANES*ADDR_W-1:0] bank_addr;
  logic [DW_ALL-1:0]       bank_rd_data;
  logic [DW_ALL-1:0]       pe_data;
  logic [LANES-1:0]        pe_valid;
  logic                    pe_ready = 1'b0;
  logic [LW-1:0]           fifo_level;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  pe_operand_fetch #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES),
    .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .valid(valid), .addr_bus(addr_bus),
    .fetch_ready(fetch_ready), .bank_rd_en(bank_rd_en), .bank_addr(bank_addr),
    .bank_rd_data(bank_rd_data), .pe_data(pe_data), .pe_valid(pe_valid),
    .pe_ready(pe_ready), .fifo_level(fifo_level)
  );

  // Bank contents: a fixed function of lane and address.
  function automatic logic [DATA_W-1:0] lane_data(input int lane, input logic [ADDR_W-1:0] a);
    return (a[7:0] ^ 8'hB5) + 8'(lane * 17);
  endfunction

  function automatic logic [LANES-1:0] pad_of(input logic [LANES*ADDR_W-1:0] ab);
    logic [LANES-1:0] p;
    p = '0;
`ifdef PE_FETCH_ZERO_PAD_EN
    for (int i = 0; i < LANES; i++)
      p[i] = (ab[i*ADDR_W +: ADDR_W] == 13'h1FFF);
`endif
    return p;
  endfunction

  // SRAM responder: unread lanes return garbage so masking is observable.
  logic [DW_ALL-1:0] sram_pipe [RD_LAT];
  always @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      sram_pipe[0][i*DATA_W +: DATA_W] <= bank_rd_en[i] ?
        lane_data(i, bank_addr[i*ADDR_W +: ADDR_W]) : 8'hEE;
    for (int s = 1; s < RD_LAT; s++)
      sram_pipe[s] <= sram_pipe[s-1];
  end
  assign bank_rd_data = sram_pipe[RD_LAT-1];

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard model ----------------
  logic [BW-1:0]    exp_q  [$];
  logic [BW-1:0]    pend_q [$];
  int               pend_at [$];
  int               cyc = 0;
  logic [BW-1:0]    m_beat;
  logic [LANES-1:0] m_pad;
  logic [LANES-1:0] m_pv;
  logic [DW_ALL-1:0] m_pd;
  logic             m_ready;
  logic             m_fire;

  always @(negedge clk) begin
    m_pad   = pad_of(addr_bus);
    m_pv    = (exp_q.size() > 0) ? exp_q[0][BW-1 -: LANES] : '0;
    m_pd    = (exp_q.size() > 0) ? exp_q[0][DW_ALL-1:0] : '0;
    m_ready = !reset && ((pend_q.size() + exp_q.size()) < FIFO_DEPTH);
    m_fire  = en && (valid != '0) && m_ready;
    chk("fetch_ready", BW'(fetch_ready), BW'(m_ready));
    chk("bank_rd_en", BW'(bank_rd_en), BW'(m_fire ? (valid & ~m_pad) : '0));
    chk("bank_addr", BW'(bank_addr), BW'(addr_bus));
    chk("pe_valid", BW'(pe_valid), BW'(m_pv));
    chk("pe_data", BW'(pe_data), BW'(m_pd));
    chk("fifo_level", BW'(fifo_level), BW'(exp_q.size()));
    if (reset) begin
      exp_q.delete();
      pend_q.delete();
      pend_at.delete();
    end else begin
      if (exp_q.size() > 0 && pe_ready)
        void'(exp_q.pop_front());
      if (pend_q.size() > 0 && pend_at[0] == cyc) begin
        exp_q.push_back(pend_q.pop_front());
        void'(pend_at.pop_front());
      end
      if (m_fire) begin
        m_beat = '0;
        m_beat[BW-1 -: LANES] = valid;
        for (int i = 0; i < LANES; i++)
          if (valid[i] && !m_pad[i])
            m_beat[i*DATA_W +: DATA_W] = lane_data(i, addr_bus[i*ADDR_W +: ADDR_W]);
        pend_q.push_back(m_beat);
        pend_at.push_back(cyc + RD_LAT);
      end
    end
    cyc++;
  end

  // ---------------- driver ----------------
  // One call = one cycle; returns at the falling edge of that cycle.
  task automatic set_in(input logic r, input logic e, input logic [LANES-1:0] v,
                        input logic [ADDR_W-1:0] base, input logic rdy);
    @(posedge clk);
    #1;
    reset = r;
    en    = e;
    valid = v;
    for (int i = 0; i < LANES; i++)
      addr_bus[i*ADDR_W +: ADDR_W] = base + ADDR_W'(i * 257);
    pe_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) set_in(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  logic [LANES-1:0] mix_masks [6] = '{16'h1234, 16'hFFFF, 16'h0001, 16'h8000, 16'hF00F, 16'h0FF0};
  logic [LANES-1:0] gap_masks [3] = '{16'h00F0, 16'h8001, 16'h5A5A};

  initial begin
    set_in(1'b1, 1'b0, '0, '0, 1'b0);
    set_in(1'b1, 1'b0, '0, '0, 1'b0);
    set_in(1'b0, 1'b0, '0, '0, 1'b0);
    chk("reset_level", BW'(fifo_level), BW'(0));
    chk("reset_pe_valid", BW'(pe_valid), BW'(0));
    chk("reset_pe_data", BW'(pe_data), BW'(0));

    // Single beat
    set_in(1'b0, 1'b1, 16'h0001, 13'h0010, 1'b1);
    chk("single_rd_en", BW'(bank_rd_en), BW'(16'h0001));
    set_in(1'b0, 1'b0, '0, '0, 1'b1);
    chk("single_not_yet", BW'(pe_valid), BW'(0));
    set_in(1'b0, 1'b0, '0, '0, 1'b1);
    chk("single_pe_valid", BW'(pe_valid), BW'(16'h0001));
    chk("single_pe_data", BW'(pe_data), BW'({120'h0, 8'hA5}));
    set_in(1'b0, 1'b0, '0, '0, 1'b1);
    chk("single_drained", BW'(fifo_level), BW'(0));

    // Full-mask streaming
    for (int k = 0; k < 20; k++) begin
      set_in(1'b0, 1'b1, 16'hFFFF, ADDR_W'(k * 55), 1'b1);
      chk("stream_ready", BW'(fetch_ready), BW'(1));
      chk("stream_level_le2", BW'(fifo_level <= 2), BW'(1));
    end
    idle(4);

    // Backpressure
    for (int k = 0; k < 6; k++)
      set_in(1'b0, 1'b1, 16'hFFFF, ADDR_W'(13'h0400 + k * 3), 1'b0);
    chk("bp_level", BW'(fifo_level), BW'(4));
    chk("bp_ready", BW'(fetch_ready), BW'(0));
    chk("bp_rd_en", BW'(bank_rd_en), BW'(0));
    idle(6);

    // en / valid gaps
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 1'b1, gap_masks[k], ADDR_W'(13'h0800 + k * 7), 1'b1);
      set_in(1'b0, 1'b0, gap_masks[k], ADDR_W'(13'h0900 + k * 7), 1'b1);
      chk("gap_en0_rd_en", BW'(bank_rd_en), BW'(0));
      set_in(1'b0, 1'b1, '0, ADDR_W'(13'h0A00 + k * 7), 1'b1);
      chk("gap_valid0_rd_en", BW'(bank_rd_en), BW'(0));
    end
    idle(3);

    // Mixed traffic with intermittent pe_ready
    for (int k = 0; k < 18; k++)
      set_in(1'b0, (k % 4) != 3, mix_masks[k % 6], ADDR_W'(k * 163 + 256), (k % 3) != 1);
    idle(8);

    // Reset mid-operation: 2 beats in FIFO, 1 in flight
    for (int k = 0; k < 3; k++)
      set_in(1'b0, 1'b1, 16'hFFFF, ADDR_W'(13'h0200 + k), 1'b0);
    set_in(1'b1, 1'b0, '0, '0, 1'b0);
    chk("pre_reset_level", BW'(fifo_level), BW'(2));
    set_in(1'b0, 1'b0, '0, '0, 1'b0);
    chk("post_reset_level", BW'(fifo_level), BW'(0));
    chk("post_reset_pe_valid", BW'(pe_valid), BW'(0));
    idle(3);
    chk("late_data_dropped", BW'(fifo_level), BW'(0));

    // Padding lane (lane1 address 13'h1FFF)
    set_in(1'b0, 1'b1, 16'h0003, 13'h1EFE, 1'b1);
`ifdef PE_FETCH_ZERO_PAD_EN
    chk("pad_rd_en", BW'(bank_rd_en), BW'(16'h0001));
`else
    chk("pad_rd_en", BW'(bank_rd_en), BW'(16'h0003));
`endif
    set_in(1'b0, 1'b0, '0, '0, 1'b1);
    set_in(1'b0, 1'b0, '0, '0, 1'b1);
    chk("pad_pe_valid", BW'(pe_valid), BW'(16'h0003));
`ifdef PE_FETCH_ZERO_PAD_EN
    chk("pad_pe_data", BW'(pe_data), BW'({112'h0, 8'h00, 8'h4B}));
`else
    chk("pad_pe_data", BW'(pe_data), BW'({112'h0, 8'h5B, 8'h4B}));
`endif
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
